// File: rtl/serial_frame_transmitter_if.sv
// Handshake and serial-line bundle for serial_frame_transmitter.
// The master side supplies words; the slave side is the transmitter.
interface serial_frame_transmitter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, sout, busy, done
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, sout, busy, done
    );
endinterface

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial frame launcher: start bit, LSB-first data, optional parity, stop bit.
// Every output is driven straight from a flop, so the far end can capture sout on negedge.
module serial_frame_transmitter #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_frame_transmitter_if.slave tx
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
    localparam bit ODD_PAR = (PARITY == 2);

    if (PARITY > 2) begin : g_parity_warn
        $warning("serial_frame_transmitter: PARITY=%0d unsupported, no parity bit sent", PARITY);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sout_q, sout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            sout_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // sout_d always carries the level for the *next* bit, so each
    // transition updates the line on the same edge the state changes.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                if (tx.tx_valid && ready_q) begin
                    shift_d   = tx.tx_data;
                    par_d     = ODD_PAR ? ~^tx.tx_data : ^tx.tx_data;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    sout_d    = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    sout_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (HAS_PAR) begin
                            sout_d  = par_q;
                            state_d = S_PARITY;
                        end else begin
                            sout_d  = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sout_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    sout_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx.tx_ready = ready_q;
    assign tx.sout     = sout_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench: four transmitter configurations checked cycle by cycle
// against a frame-level reference model of the serial waveform.
module tb_serial_frame_transmitter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // dut0: 8/4/none, dut1: 8/4/even, dut2: 8/4/odd, dut3: 8/1/none
    int par_tab [4] = '{0, 1, 2, 0};
    int cpb_tab [4] = '{4, 4, 4, 1};

    logic       valid_r [4];
    logic [7:0] data_r  [4];
    logic       sout_w  [4];
    logic       ready_w [4];
    logic       busy_w  [4];
    logic       done_w  [4];

    logic obs_sout  [128];
    logic obs_ready [128];
    logic obs_busy  [128];
    logic obs_done  [128];

    serial_frame_transmitter_if #(.WIDTH(8)) if0 ();
    serial_frame_transmitter_if #(.WIDTH(8)) if1 ();
    serial_frame_transmitter_if #(.WIDTH(8)) if2 ();
    serial_frame_transmitter_if #(.WIDTH(8)) if3 ();

    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0))
        u0 (.clk(clk), .rst(rst), .tx(if0));
    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1))
        u1 (.clk(clk), .rst(rst), .tx(if1));
    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2))
        u2 (.clk(clk), .rst(rst), .tx(if2));
    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY(0))
        u3 (.clk(clk), .rst(rst), .tx(if3));

    assign if0.tx_valid = valid_r[0];
    assign if0.tx_data  = data_r[0];
    assign if1.tx_valid = valid_r[1];
    assign if1.tx_data  = data_r[1];
    assign if2.tx_valid = valid_r[2];
    assign if2.tx_data  = data_r[2];
    assign if3.tx_valid = valid_r[3];
    assign if3.tx_data  = data_r[3];

    assign sout_w[0] = if0.sout;  assign ready_w[0] = if0.tx_ready;
    assign busy_w[0] = if0.busy;  assign done_w[0]  = if0.done;
    assign sout_w[1] = if1.sout;  assign ready_w[1] = if1.tx_ready;
    assign busy_w[1] = if1.busy;  assign done_w[1]  = if1.done;
    assign sout_w[2] = if2.sout;  assign ready_w[2] = if2.tx_ready;
    assign busy_w[2] = if2.busy;  assign done_w[2]  = if2.done;
    assign sout_w[3] = if3.sout;  assign ready_w[3] = if3.tx_ready;
    assign busy_w[3] = if3.busy;  assign done_w[3]  = if3.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic int frame_len(input int idx);
        int nb;
        nb = 10 + ((par_tab[idx] == 1 || par_tab[idx] == 2) ? 1 : 0);
        return nb * cpb_tab[idx];
    endfunction

    // Expected line level k cycles after the accept edge (k=0 is the first start-bit cycle).
    function automatic logic exp_sout(input logic [7:0] d, input int idx, input int k);
        int nb;
        int b;
        nb = 10 + ((par_tab[idx] == 1 || par_tab[idx] == 2) ? 1 : 0);
        b  = k / cpb_tab[idx];
        if (k < 0 || b >= nb) return 1'b1;
        if (b == 0)           return 1'b0;
        if (b <= 8)           return d[b-1];
        if (b == 9 && nb == 11) begin
            if (par_tab[idx] == 1) return logic'($countones(d) % 2 == 1);
            else                   return logic'($countones(d) % 2 == 0);
        end
        return 1'b1;
    endfunction

    // Presents a word at the current negedge and records n cycles of outputs after acceptance.
    task automatic capture(input int idx, input logic [7:0] d, input int n,
                           input int drop_k, input int chg_k, input logic [7:0] chg_d);
        valid_r[idx] = 1'b1;
        data_r[idx]  = d;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs_sout[k]  = sout_w[idx];
            obs_ready[k] = ready_w[idx];
            obs_busy[k]  = busy_w[idx];
            obs_done[k]  = done_w[idx];
            if (k == drop_k) valid_r[idx] = 1'b0;
            if (k == chg_k)  data_r[idx]  = chg_d;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({sout_w[i], ready_w[i], busy_w[i], done_w[i]} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_t0 dut%0d {sout,ready,busy,done} got=%b want=1100",
                         i, {sout_w[i], ready_w[i], busy_w[i], done_w[i]});
            end
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({sout_w[i], ready_w[i], busy_w[i], done_w[i]} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_idle dut%0d {sout,ready,busy,done} got=%b want=1100",
                         i, {sout_w[i], ready_w[i], busy_w[i], done_w[i]});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] words [2];
        int f;
        words[0] = 8'hA5;
        words[1] = 8'($urandom);
        f = frame_len(0);
        foreach (words[w]) begin
            capture(0, words[w], f + 2, 0, -1, 8'h00);
            for (int k = 0; k < f + 2; k++) begin
                total++;
                if (obs_sout[k] !== exp_sout(words[w], 0, k)) begin
                    bad++;
                    $display("FAIL basic_sout data=%h cyc=%0d got=%b want=%b",
                             words[w], k, obs_sout[k], exp_sout(words[w], 0, k));
                end
                total++;
                if ({obs_done[k], obs_busy[k], obs_ready[k]} !== {k == f, k < f, k >= f}) begin
                    bad++;
                    $display("FAIL basic_flags data=%h cyc=%0d {done,busy,ready} got=%b want=%b",
                             words[w], k, {obs_done[k], obs_busy[k], obs_ready[k]},
                             {k == f, k < f, k >= f});
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        int f;
        for (int idx = 1; idx <= 2; idx++) begin
            for (int r = 0; r < 2; r++) begin
                d = (r == 0) ? 8'h07 : 8'($urandom);
                f = frame_len(idx);
                capture(idx, d, f + 2, 0, -1, 8'h00);
                for (int k = 0; k < f + 2; k++) begin
                    total++;
                    if (obs_sout[k] !== exp_sout(d, idx, k)) begin
                        bad++;
                        $display("FAIL parity%0d_sout data=%h cyc=%0d got=%b want=%b",
                                 par_tab[idx], d, k, obs_sout[k], exp_sout(d, idx, k));
                    end
                    total++;
                    if (obs_done[k] !== (k == f)) begin
                        bad++;
                        $display("FAIL parity%0d_done data=%h cyc=%0d got=%b want=%b",
                                 par_tab[idx], d, k, obs_done[k], k == f);
                    end
                end
            end
        end
    endtask

    task automatic test_cpb1();
        logic [7:0] words [2];
        int f;
        words[0] = 8'h81;
        words[1] = 8'($urandom);
        f = frame_len(3);
        foreach (words[w]) begin
            capture(3, words[w], f + 2, 0, -1, 8'h00);
            for (int k = 0; k < f + 2; k++) begin
                total++;
                if ({obs_sout[k], obs_done[k], obs_busy[k]} !==
                    {exp_sout(words[w], 3, k), k == f, k < f}) begin
                    bad++;
                    $display("FAIL cpb1 data=%h cyc=%0d {sout,done,busy} got=%b want=%b",
                             words[w], k, {obs_sout[k], obs_done[k], obs_busy[k]},
                             {exp_sout(words[w], 3, k), k == f, k < f});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        int f;
        f = frame_len(0);
        // Data switches to the second word mid-way through the first frame.
        capture(0, 8'h3C, 2 * f + 2, f + 5, 3, 8'hC3);
        for (int k = 0; k < 2 * f + 2; k++) begin
            e = (k <= f) ? exp_sout(8'h3C, 0, k) : exp_sout(8'hC3, 0, k - f - 1);
            total++;
            if (obs_sout[k] !== e) begin
                bad++;
                $display("FAIL b2b_sout cyc=%0d got=%b want=%b", k, obs_sout[k], e);
            end
            total++;
            if ({obs_done[k], obs_ready[k]} !== {2{k == f || k == 2 * f + 1}}) begin
                bad++;
                $display("FAIL b2b_flags cyc=%0d {done,ready} got=%b want=%b",
                         k, {obs_done[k], obs_ready[k]}, {2{k == f || k == 2 * f + 1}});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int f;
        f = frame_len(0);
        capture(0, 8'hFF, 22, 0, -1, 8'h00);
        total++;
        if ({obs_sout[21], obs_busy[21]} !== 2'b11) begin
            bad++;
            $display("FAIL midrst_pre {sout,busy} got=%b want=11", {obs_sout[21], obs_busy[21]});
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({sout_w[0], ready_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
            bad++;
            $display("FAIL midrst_now {sout,ready,busy,done} got=%b want=1100",
                     {sout_w[0], ready_w[0], busy_w[0], done_w[0]});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < f + 5; k++) begin
            @(negedge clk);
            total++;
            if ({sout_w[0], done_w[0], busy_w[0]} !== 3'b100) begin
                bad++;
                $display("FAIL midrst_after cyc=%0d {sout,done,busy} got=%b want=100",
                         k, {sout_w[0], done_w[0], busy_w[0]});
            end
        end
        capture(0, 8'h00, f + 2, 0, -1, 8'h00);
        for (int k = 0; k < f + 2; k++) begin
            total++;
            if ({obs_sout[k], obs_done[k]} !== {exp_sout(8'h00, 0, k), k == f}) begin
                bad++;
                $display("FAIL midrst_resend cyc=%0d {sout,done} got=%b want=%b",
                         k, {obs_sout[k], obs_done[k]}, {exp_sout(8'h00, 0, k), k == f});
            end
        end
    endtask

    task automatic test_random();
        int idx;
        int f;
        logic [7:0] d;
        for (int n = 0; n < 8; n++) begin
            idx = int'($urandom_range(0, 3));
            d   = 8'($urandom);
            f   = frame_len(idx);
            capture(idx, d, f + 2, 0, -1, 8'h00);
            for (int k = 0; k < f + 2; k++) begin
                total++;
                if ({obs_sout[k], obs_done[k], obs_busy[k]} !==
                    {exp_sout(d, idx, k), k == f, k < f}) begin
                    bad++;
                    $display("FAIL random dut%0d data=%h cyc=%0d {sout,done,busy} got=%b want=%b",
                             idx, d, k, {obs_sout[k], obs_done[k], obs_busy[k]},
                             {exp_sout(d, idx, k), k == f, k < f});
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            valid_r[i] = 1'b0;
            data_r[i]  = 8'h00;
        end
        test_reset();
        test_basic();
        test_parity();
        test_cpb1();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
